// File: rtl/paint_pkg.sv
// Shared types and sizes for the paint frame-buffer write path.
package paint_pkg;

  localparam int N_REQ   = 4;
  localparam int COORD_W = 8;
  localparam int DATA_W  = 8;
  localparam int X_BITS  = 6;
  localparam int Y_BITS  = 6;
  localparam int A_W     = X_BITS + Y_BITS;
  localparam int RR_W    = $clog2(N_REQ);

  localparam logic [RR_W-1:0] REQ_CLEAR  = RR_W'(0);
  localparam logic [RR_W-1:0] REQ_PAINT  = RR_W'(1);
  localparam logic [RR_W-1:0] REQ_CURSOR = RR_W'(2);
  localparam logic [RR_W-1:0] REQ_PALETA = RR_W'(N_REQ - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  function automatic logic [A_W-1:0] fb_lin(
    input logic [COORD_W-1:0] x,
    input logic [COORD_W-1:0] y
  );
    return {y[Y_BITS-1:0], x[X_BITS-1:0]};
  endfunction

  function automatic logic in_bounds(
    input logic [COORD_W-1:0] x,
    input logic [COORD_W-1:0] y
  );
    return ~|x[COORD_W-1:X_BITS] & ~|y[COORD_W-1:Y_BITS];
  endfunction

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Requester-side and frame-buffer-side signals of the write arbiter.
interface fb_write_arbiter_if;
  import paint_pkg::*;

  logic [N_REQ-1:0]         req;
  logic [N_REQ-1:0]         last;
  logic [N_REQ*COORD_W-1:0] x_in;
  logic [N_REQ*COORD_W-1:0] y_in;
  logic [N_REQ*DATA_W-1:0]  d_in;
  logic [N_REQ-1:0]         gnt;
  logic [N_REQ-1:0]         done;
  logic                     fb_we;
  logic [A_W-1:0]           fb_addr;
  logic [DATA_W-1:0]        fb_data;
  logic                     fb_ready;
  logic                     oob_err;

  modport master (
    output req, last, x_in, y_in, d_in,
    output fb_ready,
    input  gnt, done,
    input  fb_we, fb_addr, fb_data,
    input  oob_err
  );

  modport slave (
    input  req, last, x_in, y_in, d_in,
    input  fb_ready,
    output gnt, done,
    output fb_we, fb_addr, fb_data,
    output oob_err
  );

endinterface

// File: rtl/fb_write_arbiter_rr_pick.sv
// Rotating-priority one-hot pick over requesters 1..N_REQ-1.
module rr_pick
  import paint_pkg::*;
(
  input  logic [RR_W-1:0]  rr_ptr,
  input  logic [N_REQ-1:1] mask,
  output logic [N_REQ-1:0] win,
  output logic             valid
);

  logic [N_REQ-1:0] m;
  int               idx;

  assign m = {mask, 1'b0};

  // Offset keeps the modulo argument non-negative for any rr_ptr.
  always_comb begin
    win   = '0;
    valid = 1'b0;
    idx   = 1;
    for (int k = 0; k < N_REQ - 1; k++) begin
      idx = ((int'(rr_ptr) + N_REQ - 2 + k) % (N_REQ - 1)) + 1;
      if (!valid && m[idx]) begin
        win[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Burst-atomic arbiter for the single frame-buffer write port.
module fb_write_arbiter
  import paint_pkg::*;
(
  input logic               clk,
  input logic               rst,
  fb_write_arbiter_if.slave bus
);

  state_t              state, state_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [N_REQ-1:0]    done_q, done_d;
  logic [RR_W-1:0]     rr_ptr, rr_d;
  logic [N_REQ-1:0]    pick;
  logic                pick_v;

  logic                fb_we_q;
  logic [A_W-1:0]      fb_addr_q;
  logic [DATA_W-1:0]   fb_data_q;
  logic                oob_q;

  logic [COORD_W-1:0]  sel_x, sel_y;
  logic [DATA_W-1:0]   sel_d;
  logic [RR_W-1:0]     widx;
  logic                take, beat, beat_last, in_rng;

  rr_pick u_pick (
    .rr_ptr (rr_ptr),
    .mask   (bus.req[N_REQ-1:1]),
    .win    (pick),
    .valid  (pick_v)
  );

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    sel_d = '0;
    widx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_q[i]) begin
        sel_x = bus.x_in[i*COORD_W +: COORD_W];
        sel_y = bus.y_in[i*COORD_W +: COORD_W];
        sel_d = bus.d_in[i*DATA_W +: DATA_W];
        widx  = RR_W'(i);
      end
    end
  end

  // Output register drains this edge or is empty: no bubble at full rate.
  assign take      = !fb_we_q || bus.fb_ready;
  assign beat      = (state == ST_BURST) && |(gnt_q & bus.req) && take;
  assign beat_last = beat && |(gnt_q & bus.last);
  assign in_rng    = in_bounds(sel_x, sel_y);

  always_comb begin
    state_d = state;
    gnt_d   = gnt_q;
    done_d  = '0;
    rr_d    = rr_ptr;
    unique case (state)
      ST_IDLE: begin
        priority case (1'b1)
          bus.req[REQ_CLEAR]: begin
            gnt_d   = N_REQ'(1);
            state_d = ST_BURST;
          end
          pick_v: begin
            gnt_d   = pick;
            state_d = ST_BURST;
          end
          default: ;
        endcase
      end
      ST_BURST: begin
        if (beat_last) begin
          done_d  = gnt_q;
          gnt_d   = '0;
          state_d = ST_IDLE;
          if (widx != REQ_CLEAR)
            rr_d = (widx == REQ_PALETA) ? REQ_PAINT
                                        : widx + RR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      gnt_q  <= '0;
      done_q <= '0;
      rr_ptr <= REQ_PAINT;
    end else begin
      state  <= state_d;
      gnt_q  <= gnt_d;
      done_q <= done_d;
      rr_ptr <= rr_d;
    end
  end

  // Out-of-range beats still count toward the burst but never write.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      fb_we_q   <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
      oob_q     <= 1'b0;
    end else if (beat) begin
      if (in_rng) begin
        fb_we_q   <= 1'b1;
        fb_addr_q <= fb_lin(sel_x, sel_y);
        fb_data_q <= sel_d;
      end else begin
        fb_we_q <= 1'b0;
        oob_q   <= 1'b1;
      end
    end else if (bus.fb_ready) begin
      fb_we_q <= 1'b0;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.fb_we   = fb_we_q;
  assign bus.fb_addr = fb_addr_q;
  assign bus.fb_data = fb_data_q;
  assign bus.oob_err = oob_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: vector table plus burst sequences.
module tb_fb_write_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fb_write_arbiter_if bus();

  fb_write_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] a;
    logic [7:0]  d;
    int          c;
  } wr_t;

  typedef struct {
    int          r;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [7:0]  d;
    logic        we;
    logic [11:0] a;
    logic        oob;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  int         cnt[4];
  int         idx[4];
  logic [7:0] bx[4], by[4], bd[4];
  bit         refill[4];
  int         last_acc[4];
  bit         rdy;
  int         cyc;
  wr_t        wq[$];
  logic [3:0] gq[$];
  int         gcq[$];
  logic [3:0] gprev;
  logic [3:0] done_seen;
  logic [3:0] acc;
  bit         hold_we;
  logic [11:0] hold_a;
  logic [7:0] hold_d;
  int         stall_viol;
  int         hold_cyc;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic clr_model();
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0; idx[i] = 0; refill[i] = 0;
      bx[i] = '0; by[i] = '0; bd[i] = '0;
      last_acc[i] = 0;
    end
    wq.delete(); gq.delete(); gcq.delete();
    gprev = '0; done_seen = '0; hold_we = 0;
    stall_viol = 0; hold_cyc = 0;
  endtask

  // Drive at posedge, observe the negedge update 1 time unit later.
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.req[i]  = cnt[i] > 0;
      bus.last[i] = cnt[i] == 1;
      bus.x_in[i*8 +: 8] = bx[i] + 8'(idx[i]);
      bus.y_in[i*8 +: 8] = by[i];
      bus.d_in[i*8 +: 8] = bd[i] + 8'(idx[i]);
    end
    bus.fb_ready = rdy;
    #1;
    if (hold_we && (bus.fb_we !== 1'b1 || bus.fb_addr !== hold_a ||
                    bus.fb_data !== hold_d))
      stall_viol++;
    if (bus.fb_we && bus.fb_ready)
      wq.push_back('{bus.fb_addr, bus.fb_data, cyc});
    hold_we = bus.fb_we && !bus.fb_ready;
    hold_a  = bus.fb_addr;
    hold_d  = bus.fb_data;
    if (hold_we) hold_cyc++;
    acc = bus.gnt & bus.req & {4{!bus.fb_we || bus.fb_ready}};
    @(negedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        idx[i]++;
        cnt[i]--;
        last_acc[i] = cyc;
        if (cnt[i] == 0 && refill[i]) cnt[i] = 1;
      end
    end
    if (bus.gnt != 4'b0 && gprev == 4'b0) begin
      gq.push_back(bus.gnt);
      gcq.push_back(cyc);
    end
    gprev = bus.gnt;
    done_seen |= bus.done;
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #2 rst = 1'b1;
    clr_model();
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  vec_t       tv[7];
  logic [3:0] exp_g[6];
  int         bad;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    tv[0] = '{1, 8'd5,  8'd3,  8'h2A, 1'b1, 12'd197,  1'b0};
    tv[1] = '{2, 8'd0,  8'd0,  8'h11, 1'b1, 12'd0,    1'b0};
    tv[2] = '{3, 8'd63, 8'd63, 8'hC3, 1'b1, 12'd4095, 1'b0};
    tv[3] = '{0, 8'd10, 8'd1,  8'h5E, 1'b1, 12'd74,   1'b0};
    tv[4] = '{1, 8'd63, 8'd0,  8'h07, 1'b1, 12'd63,   1'b0};
    tv[5] = '{1, 8'd70, 8'd3,  8'h99, 1'b0, 12'd0,    1'b1};
    tv[6] = '{2, 8'd4,  8'd64, 8'h42, 1'b0, 12'd0,    1'b1};
    exp_g = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000};

    bus.req = '0; bus.last = '0;
    bus.x_in = '0; bus.y_in = '0; bus.d_in = '0;
    bus.fb_ready = 1'b1;
    rdy = 1'b1;
    cyc = 0;
    clr_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst gnt", 32'(bus.gnt), 0);
    chk("rst done", 32'(bus.done), 0);
    chk("rst fb_we", 32'(bus.fb_we), 0);
    chk("rst fb_addr", 32'(bus.fb_addr), 0);
    chk("rst fb_data", 32'(bus.fb_data), 0);
    chk("rst oob_err", 32'(bus.oob_err), 0);
    #1 rst = 1'b0;

    // Single-beat bursts: grant after 1 edge, write and done after 2.
    for (int k = 0; k < 7; k++) begin
      bx[tv[k].r] = tv[k].x;
      by[tv[k].r] = tv[k].y;
      bd[tv[k].r] = tv[k].d;
      idx[tv[k].r] = 0;
      cnt[tv[k].r] = 1;
      step();
      chk($sformatf("vec%0d gnt", k), 32'(bus.gnt), 32'(4'b1 << tv[k].r));
      step();
      chk($sformatf("vec%0d done", k), 32'(bus.done), 32'(4'b1 << tv[k].r));
      chk($sformatf("vec%0d fb_we", k), 32'(bus.fb_we), 32'(tv[k].we));
      if (tv[k].we)
        chk($sformatf("vec%0d addr/data", k),
            32'({bus.fb_addr, bus.fb_data}), 32'({tv[k].a, tv[k].d}));
      step();
      step();
      chk($sformatf("vec%0d we idle", k), 32'(bus.fb_we), 0);
      chk($sformatf("vec%0d oob_err", k), 32'(bus.oob_err), 32'(tv[k].oob));
    end

    // Cursor burst of 9 with a paint request arriving mid-burst.
    clr_model();
    bx[2] = 8'd0; by[2] = 8'd2; bd[2] = 8'h80; cnt[2] = 9;
    bx[1] = 8'd8; by[1] = 8'd8; bd[1] = 8'h55;
    for (int s = 0; s < 30; s++) begin
      if (idx[2] == 3 && idx[1] == 0 && cnt[1] == 0) cnt[1] = 1;
      step();
    end
    chk("cursor wr count", 32'(wq.size()), 10);
    bad = 0;
    if (wq.size() >= 10) begin
      for (int k = 0; k < 9; k++)
        if (wq[k].a != 12'(128 + k) || wq[k].d != 8'(8'h80 + k) ||
            wq[k].c != wq[0].c + k)
          bad++;
      chk("paint after cursor", 32'({wq[9].a, wq[9].d}), 32'({12'd520, 8'h55}));
    end else begin
      bad = 1;
    end
    chk("cursor seq", 32'(bad), 0);
    chk("cursor grant order", 32'(gq.size() >= 2 ? {gq[0], gq[1]} : 8'hFF),
        32'({4'b0100, 4'b0010}));
    // Accept edge releases, next edge is idle-arbitrate and grants.
    chk("gnt handoff", 32'(gcq.size() >= 2 ? gcq[1] - last_acc[2] : -1), 1);

    // Reset mid-burst.
    clr_model();
    bx[2] = 8'd0; by[2] = 8'd1; bd[2] = 8'h20; cnt[2] = 5;
    for (int s = 0; s < 10 && idx[2] < 2; s++) step();
    chk("pre-rst fb_we", 32'(bus.fb_we), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid rst gnt", 32'(bus.gnt), 0);
    chk("mid rst fb_we", 32'(bus.fb_we), 0);
    chk("mid rst oob_err", 32'(bus.oob_err), 0);
    chk("mid rst done", 32'(bus.done), 0);
    clr_model();
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) step();
    chk("post rst writes", 32'(wq.size()), 0);
    chk("post rst done", 32'(done_seen), 0);

    // Round robin across 1,2,3 with requests held continuously.
    reset_dut();
    for (int i = 1; i < 4; i++) begin
      bx[i] = 8'(i); by[i] = 8'd20; bd[i] = 8'(i * 16);
      cnt[i] = 1; refill[i] = 1;
    end
    for (int s = 0; s < 40 && gq.size() < 6; s++) step();
    for (int i = 1; i < 4; i++) refill[i] = 0;
    for (int s = 0; s < 20; s++) step();
    chk("rr grants", 32'(gq.size() >= 6), 1);
    for (int k = 0; k < 6; k++)
      chk($sformatf("rr grant %0d", k),
          32'(k < gq.size() ? gq[k] : 4'hF), 32'(exp_g[k]));

    // Clear and palette together: clear runs its whole sweep first.
    reset_dut();
    bx[0] = 8'd0; by[0] = 8'd5; bd[0] = 8'h00; cnt[0] = 64;
    bx[3] = 8'd1; by[3] = 8'd1; bd[3] = 8'hEE; cnt[3] = 1;
    for (int s = 0; s < 80; s++) step();
    chk("prio grants", 32'(gq.size() >= 2 ? {gq[0], gq[1]} : 8'hFF),
        32'({4'b0001, 4'b1000}));
    chk("prio wr count", 32'(wq.size()), 65);
    bad = 0;
    if (wq.size() == 65) begin
      for (int k = 0; k < 64; k++)
        if (wq[k].a != 12'(320 + k) || wq[k].d != 8'(k)) bad++;
      chk("palette after clear", 32'({wq[64].a, wq[64].d}), 32'({12'd65, 8'hEE}));
    end else begin
      bad = 1;
    end
    chk("clear seq", 32'(bad), 0);
    chk("prio done", 32'(done_seen), 32'(4'b1001));

    // RAM stall for 4 cycles in the middle of a 6-beat paint burst.
    reset_dut();
    bx[1] = 8'd0; by[1] = 8'd10; bd[1] = 8'h30; cnt[1] = 6;
    for (int s = 0; s < 30; s++) begin
      rdy = !(s >= 4 && s < 8);
      step();
    end
    rdy = 1'b1;
    chk("stall wr count", 32'(wq.size()), 6);
    bad = 0;
    for (int k = 0; k < wq.size() && k < 6; k++)
      if (wq[k].a != 12'(640 + k) || wq[k].d != 8'(8'h30 + k)) bad++;
    chk("stall seq", 32'(bad), 0);
    chk("stall hold stable", 32'(stall_viol), 0);
    chk("stall hold cycles", 32'(hold_cyc), 4);
    chk("stall done", 32'(done_seen), 32'(4'b0010));
    chk("stall oob clean", 32'(bus.oob_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
